// File: rtl/fsm_seq_det_pkg.sv
// Shared types and helpers for the fsm_seq_det pattern detector.
// Holds the control-state enum, symbol classes and the clog2 helper.
package fsm_seq_det_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SYM_HOLD,
    SYM_ADV,
    SYM_DONE,
    SYM_MISS
  } sym_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fsm_seq_pat_regs.sv
// Pattern slot register file for fsm_seq_det.
// One write port, all N slots read in parallel.
module fsm_seq_pat_regs
  import fsm_seq_det_pkg::*;
#(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [clog2(N)-1:0]   idx,
  input  logic [W-1:0]          val,
  output logic [N-1:0][W-1:0]   pat
);

  localparam int IW = clog2(N);

  logic idx_ok;

  // Only non-power-of-two depths can see an out-of-range index.
  generate
    if ((1 << IW) > N) begin : g_chk
      assign idx_ok = (32'(idx) < 32'(N));
    end else begin : g_full
      assign idx_ok = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat <= '0;
    end else if (we && idx_ok) begin
      pat[idx] <= val;
    end
  end

endmodule

// File: rtl/fsm_seq_det.sv
// Programmable N-symbol sequence detector with IDLE/RUN control,
// restart-only mismatch recovery and a saturating match counter.
module fsm_seq_det
  import fsm_seq_det_pkg::*;
#(
  parameter int W       = 8,
  parameter int N       = 4,
  parameter int OVERLAP = 1,
  parameter int CW      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pat_we,
  input  logic [clog2(N)-1:0]   pat_idx,
  input  logic [W-1:0]          pat_val,
  input  logic                  in_valid,
  input  logic [W-1:0]          in_val,
  output logic                  match,
  output logic [CW-1:0]         out_val,
  output logic [clog2(N+1)-1:0] progress,
  output logic                  busy
);

  localparam int PW = clog2(N+1);

  state_t state;
  state_t state_nxt;
  sym_t   sym;

  logic [N-1:0][W-1:0] pat;
  logic [W-1:0]        cur;
  logic                hit;
  logic                first;
  logic                last;
  logic                pat_wr;

  logic [PW-1:0] prog_d;
  logic [CW-1:0] cnt_d;
  logic          match_d;

  assign pat_wr = pat_we && (state == IDLE);

  fsm_seq_pat_regs #(
    .W (W),
    .N (N)
  ) u_pat (
    .clk (clk),
    .rst (rst),
    .we  (pat_wr),
    .idx (pat_idx),
    .val (pat_val),
    .pat (pat)
  );

  always_comb begin
    cur = pat[0];
    for (int i = 1; i < N; i++) begin
      if (progress == PW'(i)) begin
        cur = pat[i];
      end
    end
  end

  always_comb begin
    hit   = (in_val == cur);
    first = (in_val == pat[0]);
    last  = (progress == PW'(N-1));
    sym   = SYM_HOLD;
    unique case (1'b1)
      !in_valid:                   sym = SYM_HOLD;
      in_valid && hit && last:     sym = SYM_DONE;
      in_valid && hit && !last:    sym = SYM_ADV;
      in_valid && !hit:            sym = SYM_MISS;
      default:                     sym = SYM_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    prog_d  = progress;
    cnt_d   = out_val;
    match_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) begin
          prog_d = '0;
          cnt_d  = '0;
        end
      end
      RUN: begin
        unique case (sym)
          SYM_DONE: begin
            match_d = 1'b1;
            cnt_d   = (&out_val) ? out_val : out_val + 1'b1;
            prog_d  = (OVERLAP != 0 && first) ? PW'(1) : '0;
          end
          SYM_ADV:  prog_d = progress + 1'b1;
          SYM_MISS: prog_d = first ? PW'(1) : '0;
          default:  prog_d = progress;
        endcase
        // A completing symbol alongside stop still counts.
        if (stop) begin
          prog_d = '0;
        end
      end
      default: begin
        prog_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      progress <= '0;
      out_val  <= '0;
      match    <= 1'b0;
    end else begin
      progress <= prog_d;
      out_val  <= cnt_d;
      match    <= match_d;
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_fsm_seq_det.sv
// Self-checking bench for fsm_seq_det: three configurations
// (overlap, non-overlap, CW=2) driven by shared stimulus.
module tb_fsm_seq_det;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       pat_we;
  logic [1:0] pat_idx;
  logic [7:0] pat_val;
  logic       in_valid;
  logic [7:0] in_val;

  logic       m0, m1, m2;
  logic [7:0] ov0, ov1;
  logic [1:0] ov2;
  logic [2:0] pr0, pr1, pr2;
  logic       bz0, bz1, bz2;

  always #5 clk = ~clk;

  fsm_seq_det #(.W(8), .N(4), .OVERLAP(1), .CW(8)) u0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .pat_we(pat_we), .pat_idx(pat_idx), .pat_val(pat_val),
    .in_valid(in_valid), .in_val(in_val),
    .match(m0), .out_val(ov0), .progress(pr0), .busy(bz0));

  fsm_seq_det #(.W(8), .N(4), .OVERLAP(0), .CW(8)) u1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .pat_we(pat_we), .pat_idx(pat_idx), .pat_val(pat_val),
    .in_valid(in_valid), .in_val(in_val),
    .match(m1), .out_val(ov1), .progress(pr1), .busy(bz1));

  fsm_seq_det #(.W(8), .N(4), .OVERLAP(1), .CW(2)) u2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .pat_we(pat_we), .pat_idx(pat_idx), .pat_val(pat_val),
    .in_valid(in_valid), .in_val(in_val),
    .match(m2), .out_val(ov2), .progress(pr2), .busy(bz2));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: integer progress/count per configuration.
  bit         m_run;
  logic [7:0] m_pat [4];
  int         m_prog [3];
  int         m_cnt [3];
  bit         m_mt [3];
  int         ovl [3]  = '{1, 0, 1};
  int         cmax [3] = '{255, 255, 3};

  function automatic void model_reset();
    m_run = 1'b0;
    for (int i = 0; i < 4; i++) m_pat[i] = 8'h00;
    for (int k = 0; k < 3; k++) begin
      m_prog[k] = 0;
      m_cnt[k]  = 0;
      m_mt[k]   = 1'b0;
    end
  endfunction

  function automatic void model_step();
    for (int k = 0; k < 3; k++) m_mt[k] = 1'b0;
    if (!m_run) begin
      if (pat_we) m_pat[pat_idx] = pat_val;
      if (start && !stop) begin
        m_run = 1'b1;
        for (int k = 0; k < 3; k++) begin
          m_prog[k] = 0;
          m_cnt[k]  = 0;
        end
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (in_valid) begin
          if (in_val == m_pat[m_prog[k]]) begin
            if (m_prog[k] == 3) begin
              m_mt[k] = 1'b1;
              if (m_cnt[k] < cmax[k]) m_cnt[k]++;
              m_prog[k] = (ovl[k] != 0 && in_val == m_pat[0]) ? 1 : 0;
            end else begin
              m_prog[k]++;
            end
          end else begin
            m_prog[k] = (in_val == m_pat[0]) ? 1 : 0;
          end
        end
      end
      if (stop) begin
        m_run = 1'b0;
        for (int k = 0; k < 3; k++) m_prog[k] = 0;
      end
    end
  endfunction

  task automatic compare_all();
    check("u0.match", m0, m_mt[0]);
    check("u0.out_val", ov0, m_cnt[0]);
    check("u0.progress", pr0, m_prog[0]);
    check("u0.busy", bz0, m_run);
    check("u1.match", m1, m_mt[1]);
    check("u1.out_val", ov1, m_cnt[1]);
    check("u1.progress", pr1, m_prog[1]);
    check("u1.busy", bz1, m_run);
    check("u2.match", m2, m_mt[2]);
    check("u2.out_val", ov2, m_cnt[2]);
    check("u2.progress", pr2, m_prog[2]);
    check("u2.busy", bz2, m_run);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle_in();
    start    = 1'b0;
    stop     = 1'b0;
    pat_we   = 1'b0;
    pat_idx  = 2'd0;
    pat_val  = 8'h00;
    in_valid = 1'b0;
    in_val   = 8'h00;
  endtask

  task automatic sym(input logic [7:0] v);
    idle_in();
    in_valid = 1'b1;
    in_val   = v;
    tick();
  endtask

  task automatic ctl(input bit st, input bit sp);
    idle_in();
    start = st;
    stop  = sp;
    tick();
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d);
    logic [7:0] v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      idle_in();
      pat_we  = 1'b1;
      pat_idx = 2'(i);
      pat_val = v[i];
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit         st;
    bit         sp;
    bit         iv;
    logic [7:0] v;
    bit         em;
    int         ep;
    int         ec;
    bit         eb;
  } vec_t;

  vec_t tbl [$];

  logic [7:0] syms [4] = '{8'hA5, 8'h3C, 8'h5A, 8'hC3};

  initial begin
    int mask0;
    int mask1;
    int seq [$];
    int tgl_p [8];
    int tgl_m [8];

    rst = 1'b0;
    idle_in();
    model_reset();
    do_reset();

    load(8'hA5, 8'h3C, 8'h5A, 8'hC3);

    tbl.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 1});
    tbl.push_back('{0, 0, 1, 8'hA5, 0, 1, 0, 1});
    tbl.push_back('{0, 0, 1, 8'h3C, 0, 2, 0, 1});
    tbl.push_back('{0, 0, 1, 8'h5A, 0, 3, 0, 1});
    tbl.push_back('{0, 0, 1, 8'hC3, 1, 0, 1, 1});
    tbl.push_back('{0, 0, 0, 8'h00, 0, 0, 1, 1});
    tbl.push_back('{0, 0, 1, 8'hA5, 0, 1, 1, 1});
    tbl.push_back('{0, 0, 1, 8'h3C, 0, 2, 1, 1});
    tbl.push_back('{0, 0, 1, 8'hA5, 0, 1, 1, 1});
    tbl.push_back('{0, 0, 1, 8'h3C, 0, 2, 1, 1});
    tbl.push_back('{0, 0, 1, 8'h5A, 0, 3, 1, 1});
    tbl.push_back('{0, 0, 1, 8'hC3, 1, 0, 2, 1});
    tbl.push_back('{0, 1, 0, 8'h00, 0, 0, 2, 0});
    tbl.push_back('{1, 1, 0, 8'h00, 0, 0, 2, 0});
    tbl.push_back('{1, 0, 0, 8'h00, 0, 0, 0, 1});
    tbl.push_back('{1, 0, 1, 8'hA5, 0, 1, 0, 1});
    tbl.push_back('{0, 0, 1, 8'h3C, 0, 2, 0, 1});
    tbl.push_back('{0, 0, 1, 8'h5A, 0, 3, 0, 1});
    tbl.push_back('{0, 1, 1, 8'hC3, 1, 0, 1, 0});
    tbl.push_back('{0, 0, 0, 8'h00, 0, 0, 1, 0});

    foreach (tbl[i]) begin
      idle_in();
      start    = tbl[i].st;
      stop     = tbl[i].sp;
      in_valid = tbl[i].iv;
      in_val   = tbl[i].v;
      tick();
      check($sformatf("tbl%0d.match", i), m0, tbl[i].em);
      check($sformatf("tbl%0d.progress", i), pr0, tbl[i].ep);
      check($sformatf("tbl%0d.out_val", i), ov0, tbl[i].ec);
      check($sformatf("tbl%0d.busy", i), bz0, tbl[i].eb);
    end

    // Valid toggling: progress holds on bubbles.
    tgl_p = '{1, 1, 2, 2, 3, 3, 0, 0};
    tgl_m = '{0, 0, 0, 0, 0, 0, 1, 0};
    ctl(1, 0);
    for (int i = 0; i < 8; i++) begin
      idle_in();
      in_valid = (i % 2 == 0);
      in_val   = (i % 2 == 0) ? syms[i/2] : 8'hC3;
      tick();
      check($sformatf("tgl%0d.progress", i), pr0, tgl_p[i]);
      check($sformatf("tgl%0d.match", i), m0, tgl_m[i]);
    end

    // Pattern writes in RUN are ignored.
    idle_in();
    pat_we  = 1'b1;
    pat_idx = 2'd0;
    pat_val = 8'h00;
    tick();
    sym(8'hA5);
    sym(8'h3C);
    sym(8'h5A);
    sym(8'hC3);
    check("run_we.match", m0, 1);

    // Reset mid-RUN aborts the pending match.
    sym(8'hA5);
    sym(8'h3C);
    sym(8'h5A);
    do_reset();
    sym(8'hC3);
    check("rst_mid.match", m0, 0);
    check("rst_mid.busy", bz0, 0);
    check("rst_mid.progress", pr0, 0);

    // Overlap vs non-overlap on a self-similar pattern.
    load(8'hA5, 8'hA5, 8'hA5, 8'hA5);
    ctl(1, 0);
    mask0 = 0;
    mask1 = 0;
    for (int i = 0; i < 7; i++) begin
      sym(8'hA5);
      if (m0) mask0 |= (1 << i);
      if (m1) mask1 |= (1 << i);
    end
    check("ovl1.mask", mask0, 'b1001000);
    check("ovl0.mask", mask1, 'b0001000);
    check("ovl0.progress", pr1, 3);

    // Saturation with CW=2.
    ctl(0, 1);
    ctl(1, 0);
    for (int i = 0; i < 16; i++) begin
      sym(8'hA5);
      if (m2) seq.push_back(int'(ov2));
    end
    check("sat.pulses", seq.size(), 5);
    if (seq.size() == 5) begin
      check("sat.seq0", seq[0], 1);
      check("sat.seq1", seq[1], 2);
      check("sat.seq2", seq[2], 3);
      check("sat.seq3", seq[3], 3);
      check("sat.seq4", seq[4], 3);
    end

    // Random traffic against the model.
    do_reset();
    load(8'hA5, 8'h3C, 8'h5A, 8'hC3);
    for (int n = 0; n < 3000; n++) begin
      int r;
      idle_in();
      r        = int'($urandom_range(0, 99));
      start    = (r < 4) || (r == 10);
      stop     = (r >= 4 && r < 6) || (r == 10);
      pat_we   = ($urandom_range(0, 19) == 0);
      pat_idx  = 2'($urandom_range(0, 3));
      pat_val  = syms[$urandom_range(0, 3)];
      in_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) < 5) begin
        in_val = syms[$urandom_range(0, 3)];
      end else begin
        in_val = 8'($urandom);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
